// File: rtl/seq_shift_sub_divider_pkg.sv
// Shared definitions for the sequential arithmetic unit.
// The divider and the shift-and-add multiplier controller both use these.
package seq_shift_sub_divider_pkg;

    localparam int DFLT_DATA_WIDTH = 8;
    localparam int DFLT_STATE_REG  = 4;

    // Exported state codes. These values are visible on the debug port, so keep them stable.
    typedef enum logic [DFLT_STATE_REG-1:0] {
        IDLE     = 4'd0,
        LOAD_DVS = 4'd1,
        CHECK    = 4'd2,
        ITER     = 4'd3,
        DONE     = 4'd4
    } state_e;

    // Operation the controller asks the datapath to perform on this clock.
    typedef enum logic [2:0] {
        DP_HOLD     = 3'd0,
        DP_LOAD_DVD = 3'd1,
        DP_LOAD_DVS = 3'd2,
        DP_CHECK    = 3'd3,
        DP_STEP     = 3'd4
    } dp_op_e;

endpackage

// File: rtl/seq_shift_sub_divider_shift_sub_datapath.sv
// Restoring-division datapath.
// It holds the quotient/dividend (Q), the remainder (R), the divisor (D) and the divide-by-zero flag.
// Each DP_STEP runs one shift-and-subtract iteration.
module shift_sub_datapath
    import seq_shift_sub_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DFLT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  dp_op_e                op,
    input  logic [DATA_WIDTH-1:0] data_input,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  d_zero
);

    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  dbz_q, dbz_d;

    // r_work is the shifted {R,Q} upper half. It is one bit wider than R so the bit shifted out of R is kept.
    // Before the shift R < D holds, so r_work <= 2D-1.
    // That bound means the MSB of the (DATA_WIDTH+1)-bit trial difference is set exactly when r_work < D.
    logic [DATA_WIDTH:0]   r_work;
    logic [DATA_WIDTH:0]   trial;

    // Next-value logic: operand loads, the zero-divisor check, and one restoring iteration.
    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        d_d    = d_q;
        dbz_d  = dbz_q;
        r_work = {r_q, q_q[DATA_WIDTH-1]};
        trial  = r_work - {1'b0, d_q};
        case (op)
            DP_LOAD_DVD: begin
                q_d = data_input;
                r_d = '0;
            end
            DP_LOAD_DVS: begin
                d_d = data_input;
            end
            DP_CHECK: begin
                if (d_q == '0) begin
                    q_d   = '1;
                    r_d   = q_q;
                    dbz_d = 1'b1;
                end else begin
                    dbz_d = 1'b0;
                end
            end
            DP_STEP: begin
                if (!trial[DATA_WIDTH]) begin
                    r_d = trial[DATA_WIDTH-1:0];
                    q_d = {q_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_work[DATA_WIDTH-1:0];
                    q_d = {q_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            default: begin
            end
        endcase
    end

    // Register update with synchronous reset. Reset discards any partial result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            d_q   <= d_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;
    assign d_zero      = (d_q == '0);

endmodule

// File: rtl/seq_shift_sub_divider.sv
// Sequential unsigned restoring divider, performing one shift-and-subtract step per clock.
// The dividend arrives with start and the divisor on the following cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | waiting for start; dividend captured on accept
//   LOAD_DVS | capturing divisor from data_input
//   CHECK    | divisor zero -> saturated result, else arm count
//   ITER     | one restoring step per clock, counter counts down
//   DONE     | result valid, done pulses for this cycle only
module seq_shift_sub_divider
    import seq_shift_sub_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
    parameter int STATE_REG  = DFLT_STATE_REG
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_input,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  busy,
    output logic                  done,
    output logic [STATE_REG-1:0]  p_STATE
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dp_op_e           dp_op;
    logic             d_zero;

    shift_sub_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .op          (dp_op),
        .data_input  (data_input),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .d_zero      (d_zero)
    );

    // Next-state, iteration down-counter and datapath command.
    // Unknown state codes fall back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_op   = DP_HOLD;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dp_op   = DP_LOAD_DVD;
                    state_d = LOAD_DVS;
                end
            end
            LOAD_DVS: begin
                dp_op   = DP_LOAD_DVS;
                state_d = CHECK;
            end
            CHECK: begin
                dp_op = DP_CHECK;
                if (d_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(DATA_WIDTH);
                    state_d = ITER;
                end
            end
            ITER: begin
                dp_op = DP_STEP;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign p_STATE = STATE_REG'(state_q);

endmodule
